coef_matvec_engine: RTL and testbench
=====================================

Name: coef_matvec_engine

Overview:
- Downstream consumer of the A-coefficient ROM loader.
- Captures the 16-word x 14-bit coefficient stream into a local 8x4 register file, holding one 7-bit unsigned coefficient per entry.
- After the loader signals completion, accepts 4-element input vectors and produces the 8-element result y = A·x, one row per cycle, over a valid/ready handshake.
- Sits between the coefficient loader and the downstream result sink.

Parameters:
- COEF_W, 7, width of one coefficient field.
- X_W, 8, width of one input vector element (unsigned).
- Y_W, 17, result width; must satisfy Y_W >= COEF_W+X_W+2.
- ROWS, 8, matrix rows (fixed by word packing; not to be overridden).
- COLS, 4, matrix columns (fixed; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  coefficient write strobe
- w_addr  in  4  coefficient word address
- w_data  in  14  packed coefficient word
- aload_done  in  1  loader finished (level)
- reload  in  1  pulse; re-opens coefficient loading
- x_valid  in  1  input element valid
- x_ready  out  1  input element accepted when x_valid&&x_ready
- x_data  in  X_W  input element, order x0..x3
- y_valid  out  1  result row valid
- y_ready  in  1  downstream accepts row
- y_data  out  Y_W  result row value
- y_row  out  3  row index of y_data
- vec_done  out  1  one-cycle pulse: row 7 issued
- loaded  out  1  coefficients frozen and valid

Behaviour:
- Reset (async, rst=1): state LOAD; register file, x buffer, counters cleared to 0; outputs x_ready=0, y_valid=0, y_data=0, y_row=0, vec_done=0, loaded=0.
- Word packing: col = w_addr[3:2], pair = w_addr[1:0]. w_data[13:7] goes to A[2*pair][col]; w_data[6:0] goes to A[2*pair+1][col].
- State LOAD:
  - wr_en=1 writes the addressed word at the clock edge.
  - aload_done=1 moves to COLLECT next cycle and sets loaded=1.
  - wr_en and aload_done in the same cycle: the write commits, then the transition occurs.
  - x_ready=0 in this state.
- State COLLECT:
  - x_ready=1. Each accepted beat stores x[k], k=0..3, k incrementing.
  - After the 4th beat: k wraps to 0 and the state moves to COMPUTE next cycle; x_ready=0 from that cycle.
- State COMPUTE, row counter r=0..7:
  - Whenever !y_valid || y_ready, the output register loads y_data = sum over j=0..3 of A[r][j]*x[j] (full-precision unsigned, zero-extended to Y_W), y_row=r, y_valid=1, and r increments.
  - Loading row 7 also pulses vec_done for one cycle and moves to COLLECT; r wraps to 0.
  - While y_valid=1 && y_ready=0: y_data and y_row are held stable and r does not advance.
  - y_valid drops when the held row is accepted and no new row loads.
- Latency: 4th x beat accepted at edge T gives COMPUTE at T+1, row 0 valid after edge T+2. With y_ready held high, rows 0..7 appear on 8 consecutive cycles.
- The next vector's beats may be accepted in COLLECT while row 7 is still pending on the output.
- Writes outside LOAD are ignored and the register file stays unchanged.
- aload_done is ignored outside LOAD.
- reload:
  - Honoured only in COLLECT with k=0: go to LOAD and clear loaded. The register file keeps its contents until overwritten.
  - Ignored in all other states and cases.
- Arithmetic: product 15 bits, sum of 4 products at most 129540. No overflow is possible at default widths.
- Reset mid-COMPUTE: immediate return to the reset state. A partial vector is discarded and no vec_done is issued.

Test Plan:
- Load the 16 words with A[:,0] = 1..8 and all other entries 1, assert aload_done; send x = 1,2,3,4 with y_ready=1 -> y_row 0..7 gives y_data 10..17 on 8 consecutive cycles; vec_done pulses with row 7; first y_valid occurs 2 edges after the 4th x beat.
- All coefficients 127, x all 255 -> every row 129540, no truncation.
- Same load as the first scenario; y_ready toggled 1,0,0,1,... -> each row held stable while y_ready=0; no row lost or duplicated; vec_done exactly once per vector.
- wr_en to addr 5 with data {7'd9,7'd3} in the same cycle as aload_done -> write takes effect (A[2][1]=9, A[3][1]=3); a later wr_en in COLLECT -> no change.
- rst pulsed after row 3 of a vector -> all outputs 0, loaded=0, state LOAD; new load plus vector -> correct results.
- reload in COLLECT with k=0 -> loaded=0, x_ready=0; new coefficients loaded, then aload_done -> results reflect the new matrix.

Source files
------------

// File: rtl/coef_matvec_if.sv
// Coefficient-load, input-vector and result-row signals of coef_matvec_engine.
// The engine takes the slave view; the loader, source and sink take the master view.
interface coef_matvec_if #(
   parameter int COEF_W = 7,
   parameter int X_W    = 8,
   parameter int Y_W    = 17
) ();
   logic                  wr_en;
   logic [3:0]            w_addr;
   logic [2*COEF_W-1:0]   w_data;
   logic                  aload_done;
   logic                  reload;
   logic                  x_valid;
   logic                  x_ready;
   logic [X_W-1:0]        x_data;
   logic                  y_valid;
   logic                  y_ready;
   logic [Y_W-1:0]        y_data;
   logic [2:0]            y_row;
   logic                  vec_done;
   logic                  loaded;

   modport master (
      output wr_en, w_addr, w_data, aload_done, reload, x_valid, x_data, y_ready,
      input  x_ready, y_valid, y_data, y_row, vec_done, loaded
   );
   modport slave (
      input  wr_en, w_addr, w_data, aload_done, reload, x_valid, x_data, y_ready,
      output x_ready, y_valid, y_data, y_row, vec_done, loaded
   );
endinterface

// File: rtl/coef_matvec_engine.sv
// 8x4 coefficient register file filled from the loader stream, then y = A*x
// produced one row per cycle over a valid/ready output register.
module coef_matvec_engine #(
   parameter int COEF_W = 7,
   parameter int X_W    = 8,
   parameter int Y_W    = 17
) (
   input  logic          clk,
   input  logic          rst,
   coef_matvec_if.slave  bus
);
   localparam int ROWS = 8;
   localparam int COLS = 4;

   typedef enum logic [1:0] {LOAD, COLLECT, COMPUTE} state_e;

   state_e              state_q, state_d;
   logic [COEF_W-1:0]   a_q [ROWS][COLS];
   logic [X_W-1:0]      x_q [COLS];
   logic [1:0]          k_q, k_d;
   logic                full_q, full_d;
   logic [2:0]          r_q, r_d;
   logic                y_valid_q, y_valid_d;
   logic [Y_W-1:0]      y_data_q, y_data_d;
   logic [2:0]          y_row_q, y_row_d;
   logic                vec_done_q, vec_done_d;
   logic                loaded_q, loaded_d;

   logic                x_ready, x_fire, y_load, reload_ok;
   logic [Y_W-1:0]      row_sum;

   // full_q marks the one cycle between the 4th beat and COMPUTE; no beats or reload then
   always_comb begin
      x_ready   = (state_q == COLLECT) && !full_q;
      x_fire    = x_ready && bus.x_valid;
      reload_ok = x_ready && (k_q == 2'd0) && bus.reload && !bus.x_valid;
      y_load    = (state_q == COMPUTE) && (!y_valid_q || bus.y_ready);
      row_sum   = '0;
      for (int j = 0; j < COLS; j++)
         row_sum = row_sum + Y_W'(a_q[r_q][j]) * Y_W'(x_q[j]);
   end

   always_comb begin
      state_d    = state_q;
      loaded_d   = loaded_q;
      k_d        = k_q;
      full_d     = full_q;
      r_d        = r_q;
      vec_done_d = 1'b0;
      case (state_q)
         LOAD: if (bus.aload_done) begin
            state_d  = COLLECT;
            loaded_d = 1'b1;
         end
         COLLECT: begin
            if (full_q) begin
               state_d = COMPUTE;
               full_d  = 1'b0;
            end else if (reload_ok) begin
               state_d  = LOAD;
               loaded_d = 1'b0;
            end else if (x_fire) begin
               k_d = k_q + 2'd1;
               if (k_q == 2'd3) full_d = 1'b1;
            end
         end
         COMPUTE: if (y_load) begin
            r_d = r_q + 3'd1;
            if (r_q == 3'd7) begin
               state_d    = COLLECT;
               vec_done_d = 1'b1;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_comb begin
      y_valid_d = y_valid_q;
      y_data_d  = y_data_q;
      y_row_d   = y_row_q;
      if (y_load) begin
         y_valid_d = 1'b1;
         y_data_d  = row_sum;
         y_row_d   = r_q;
      end else if (bus.y_ready) begin
         y_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= LOAD;
         k_q        <= '0;
         full_q     <= 1'b0;
         r_q        <= '0;
         y_valid_q  <= 1'b0;
         y_data_q   <= '0;
         y_row_q    <= '0;
         vec_done_q <= 1'b0;
         loaded_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         full_q     <= full_d;
         r_q        <= r_d;
         y_valid_q  <= y_valid_d;
         y_data_q   <= y_data_d;
         y_row_q    <= y_row_d;
         vec_done_q <= vec_done_d;
         loaded_q   <= loaded_d;
      end
   end

   // word {col,pair} carries rows 2*pair (high field) and 2*pair+1 (low field) of one column
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               a_q[r][c] <= '0;
         for (int c = 0; c < COLS; c++)
            x_q[c] <= '0;
      end else begin
         if (state_q == LOAD && bus.wr_en) begin
            a_q[{bus.w_addr[1:0], 1'b0}][bus.w_addr[3:2]] <= bus.w_data[2*COEF_W-1:COEF_W];
            a_q[{bus.w_addr[1:0], 1'b1}][bus.w_addr[3:2]] <= bus.w_data[COEF_W-1:0];
         end
         if (x_fire) x_q[k_q] <= bus.x_data;
      end
   end

   assign bus.x_ready  = x_ready;
   assign bus.y_valid  = y_valid_q;
   assign bus.y_data   = y_data_q;
   assign bus.y_row    = y_row_q;
   assign bus.vec_done = vec_done_q;
   assign bus.loaded   = loaded_q;
endmodule

// File: tb/tb_coef_matvec_engine.sv
// Random-stimulus bench for coef_matvec_engine against a plain matrix/vector model.
module tb_coef_matvec_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   coef_matvec_if #(.COEF_W(7), .X_W(8), .Y_W(17)) bus ();
   coef_matvec_engine #(.COEF_W(7), .X_W(8), .Y_W(17)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {int row; longint val;} exp_t;
   exp_t exp_q[$];
   int   a_m [8][4];
   int   n_cmp = 0, n_bad = 0;
   int   vd_cnt = 0, vd_exp = 0, rows_acc = 0;
   int   rmode = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk); #1;
   endtask

   // y_ready driver: 0 = always ready, 1 = pattern 1,0,0,1 repeating, 2 = random
   initial begin
      bit pat [4];
      int cyc = 0;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      bus.y_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0: bus.y_ready = 1'b1;
            1: bus.y_ready = pat[cyc % 4];
            default: bus.y_ready = 1'($urandom_range(0, 1));
         endcase
         cyc++;
      end
   end

   // scoreboard: order, value, hold stability and vec_done placement of result rows
   initial begin
      bit pv = 0, pr = 0;
      longint pd = 0;
      int prow = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (pv && !pr) begin
               chk("hold_valid", longint'(bus.y_valid), 1);
               chk("hold_data", longint'(bus.y_data), pd);
               chk("hold_row", longint'(bus.y_row), prow);
            end
            if (bus.vec_done) begin
               vd_cnt++;
               chk("vec_done_row", longint'(bus.y_row), 7);
            end
            if (bus.y_valid && bus.y_ready) begin
               if (exp_q.size() == 0) chk("extra_row", exp_q.size(), 1);
               else begin
                  e = exp_q.pop_front();
                  chk("y_row", longint'(bus.y_row), e.row);
                  chk("y_data", longint'(bus.y_data), e.val);
                  rows_acc++;
               end
            end
            pv = bus.y_valid; pr = bus.y_ready; pd = bus.y_data; prow = bus.y_row;
         end else pv = 1'b0;
      end
   end

   task automatic write_word(input int addr, input logic [13:0] data, input bit done);
      bus.wr_en = 1'b1; bus.w_addr = 4'(addr); bus.w_data = data; bus.aload_done = done;
      sync();
      bus.wr_en = 1'b0; bus.aload_done = 1'b0;
   endtask

   task automatic load_matrix(input bit done);
      logic [6:0] hi, lo;
      for (int addr = 0; addr < 16; addr++) begin
         hi = 7'(a_m[2*(addr%4)][addr/4]);
         lo = 7'(a_m[2*(addr%4)+1][addr/4]);
         write_word(addr, {hi, lo}, 1'b0);
      end
      if (done) begin
         bus.aload_done = 1'b1; sync(); bus.aload_done = 1'b0;
      end
   endtask

   task automatic check_loaded(input string tag);
      @(negedge clk);
      chk({tag, "_loaded"}, longint'(bus.loaded), 1);
      chk({tag, "_x_ready"}, longint'(bus.x_ready), 1);
      sync();
   endtask

   task automatic do_reload();
      bus.reload = 1'b1; sync(); bus.reload = 1'b0;
      @(negedge clk);
      chk("reload_loaded", longint'(bus.loaded), 0);
      chk("reload_x_ready", longint'(bus.x_ready), 0);
      sync();
   endtask

   task automatic send_vec(input int x [4], input bit lat_chk);
      exp_t e;
      bit acc;
      int budget;
      for (int r = 0; r < 8; r++) begin
         e.row = r; e.val = 0;
         for (int j = 0; j < 4; j++) e.val += longint'(a_m[r][j]) * longint'(x[j]);
         exp_q.push_back(e);
      end
      vd_exp++;
      for (int k = 0; k < 4; k++) begin
         bus.x_valid = 1'b1; bus.x_data = 8'(x[k]);
         acc = 1'b0; budget = 0;
         while (!acc && budget < 100) begin
            @(negedge clk); acc = bus.x_ready;
            sync(); budget++;
         end
         if (!acc) chk("x_accept_timeout", budget, 0);
      end
      bus.x_valid = 1'b0;
      if (lat_chk) begin
         @(negedge clk); chk("lat_edge1_valid", longint'(bus.y_valid), 0);
         @(negedge clk); chk("lat_edge2_valid", longint'(bus.y_valid), 0);
         for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            chk("consec_valid", longint'(bus.y_valid), 1);
            chk("consec_row", longint'(bus.y_row), r);
         end
         sync();
      end
   endtask

   task automatic drain();
      int budget = 0;
      while (exp_q.size() != 0 && budget < 400) begin sync(); budget++; end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
      repeat (2) sync();
   endtask

   task automatic rand_matrix();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 4; c++) a_m[r][c] = int'($urandom_range(0, 127));
   endtask

   task automatic rand_vec(output int x [4]);
      for (int j = 0; j < 4; j++) x[j] = int'($urandom_range(0, 255));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_x_ready"}, longint'(bus.x_ready), 0);
      chk({tag, "_y_valid"}, longint'(bus.y_valid), 0);
      chk({tag, "_y_data"}, longint'(bus.y_data), 0);
      chk({tag, "_y_row"}, longint'(bus.y_row), 0);
      chk({tag, "_vec_done"}, longint'(bus.vec_done), 0);
      chk({tag, "_loaded"}, longint'(bus.loaded), 0);
   endtask

   initial begin
      int x [4];
      int base, budget;
      bus.wr_en = 0; bus.w_addr = 0; bus.w_data = 0; bus.aload_done = 0;
      bus.reload = 0; bus.x_valid = 0; bus.x_data = 0;
      repeat (3) @(posedge clk);
      #1 check_reset("reset");
      rst = 1'b0; mon_en = 1'b1;
      sync();

      // A[:,0] = 1..8, rest 1; x = 1,2,3,4 -> rows 10..17 back to back
      for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) a_m[r][c] = (c == 0) ? r + 1 : 1;
      load_matrix(1'b1);
      check_loaded("load1");
      x = '{1, 2, 3, 4};
      send_vec(x, 1'b1);
      drain();

      // saturated operands: every row 129540
      do_reload();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) a_m[r][c] = 127;
      load_matrix(1'b1);
      check_loaded("load_max");
      x = '{255, 255, 255, 255};
      send_vec(x, 1'b0);
      drain();

      // back-pressure with pattern 1,0,0,1
      do_reload();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) a_m[r][c] = (c == 0) ? r + 1 : 1;
      load_matrix(1'b1);
      rmode = 1;
      x = '{1, 2, 3, 4};
      send_vec(x, 1'b0);
      rand_vec(x);
      send_vec(x, 1'b0);
      drain();

      // write coinciding with aload_done commits; a write in COLLECT is ignored
      rmode = 0;
      do_reload();
      rand_matrix();
      load_matrix(1'b0);
      a_m[2][1] = 9; a_m[3][1] = 3;
      write_word(5, {7'd9, 7'd3}, 1'b1);
      check_loaded("late_write");
      write_word(5, {7'd100, 7'd50}, 1'b0);
      rand_vec(x);
      send_vec(x, 1'b0);
      drain();

      // reset after row 3 of a vector
      base = rows_acc;
      rand_vec(x);
      send_vec(x, 1'b0);
      budget = 0;
      while (rows_acc < base + 4 && budget < 100) begin @(posedge clk); #2; budget++; end
      chk("row3_reached", rows_acc - base >= 4 ? 1 : 0, 1);
      mon_en = 1'b0;
      rst = 1'b1;
      #1 check_reset("midreset");
      exp_q.delete();
      vd_exp--;
      sync();
      rst = 1'b0; mon_en = 1'b1;
      sync();
      rand_matrix();
      load_matrix(1'b1);
      check_loaded("post_reset");
      rand_vec(x);
      send_vec(x, 1'b0);
      drain();

      // random back-to-back vectors with random back-pressure
      rmode = 2;
      do_reload();
      rand_matrix();
      load_matrix(1'b1);
      for (int v = 0; v < 6; v++) begin
         rand_vec(x);
         send_vec(x, 1'b0);
      end
      drain();

      chk("vec_done_count", vd_cnt, vd_exp);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
